mux_nx1_stream: RTL and testbench
=================================

Name: mux_nx1_stream

Overview:
- Parametrised successor to the 2:1 mux used in the ALU32 datapath.
- Selects one of N WIDTH-bit input channels and delivers the word through a registered, one-entry output stage with valid/ready handshakes on every port.
- Two selection modes: explicit select (for operand/result routing) and round-robin arbitration (for sharing one ALU result bus among several requesters).

Parameters:
- WIDTH, 32, data width of every channel and of result.
- N, 4, number of input channels (N >= 2).
- SELW, 2, width of sel/result_src; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  N*WIDTH  flattened channels; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel word valid.
- in_ready  output  N  per-channel accept strobe (combinational).
- result  output  WIDTH  registered selected word.
- result_valid  output  1  result holds an undelivered word.
- result_ready  input  1  downstream accepts result this cycle.
- result_src  output  SELW  channel index that produced result.

Behaviour:
- Reset (sampled at the clk edge while reset=1): result=0, result_valid=0, result_src=0, round-robin pointer ptr=0. Any held word is discarded.
- in_ready is all zero while reset=1.
- load_en = !result_valid | result_ready.
- Candidate channel c:
  - mode=0: c=sel, valid only if sel<N and in_valid[sel]=1. sel>=N never grants.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - No candidate: no grant.
- Grant: in_ready[c]=1 iff load_en and a candidate exists; all other in_ready bits are 0. At most one in_ready bit is high per cycle.
- Transfer: a channel transfers on a cycle where in_valid[i]=in_ready[i]=1. At that edge result<=in_data[c], result_src<=c, result_valid<=1.
- Latency: word appears on result one cycle after the transfer cycle. Throughput: 1 word/cycle when result_ready is held at 1.
- Drain:
  - result_valid=1 and result_ready=1 with no new grant -> result_valid<=0.
  - result and result_src hold their last values after drain.
  - Simultaneous drain and grant -> new word loaded, result_valid stays 1.
- Backpressure: result_valid=1 and result_ready=0 -> result, result_src, result_valid hold; in_ready=0.
- Pointer:
  - After each mode=1 grant, ptr <= (c+1) mod N; wrap from N-1 to 0.
  - ptr is unchanged by mode=0 grants and by idle cycles.
- mode or sel changes take effect combinationally on the next grant decision. An already-held result is unaffected.
- in_data of non-granted channels is ignored. Channels whose valid drops before a grant are never served.
- Reset asserted mid-stream overrides all other activity on that edge.

Test Plan:
- Reset -> after one edge with reset=1: result=0, result_valid=0, result_src=0; with all in_valid=1 and reset=1, in_ready=0.
- mode=0, sel=2, in_valid=4'b1111, channel i data=0x11111111*(i+1), result_ready=1 -> in_ready=4'b0100; next cycle result=0x33333333, result_src=2, result_valid=1.
- mode=1, in_valid=4'b1111 held, result_ready=1 -> result_src sequence 0,1,2,3,0,1 on consecutive cycles; pointer wraps 3->0.
- mode=1, in_valid=4'b1010, ptr=2 -> grants channel 3, then 1, then 3.
- Backpressure: hold result_ready=0 for 3 cycles with result_valid=1 -> result stable, in_ready=0. Raise result_ready -> next word loaded in the same cycle, result_valid stays 1.
- Instance N=3, SELW=2, mode=0, sel=3, all valid -> in_ready=3'b000, result_valid stays 0.
- Reset asserted while result_valid=1 -> result_valid=0, result=0 next edge. mode=1 after release -> first grant is the lowest valid channel from ptr=0.

Source files
------------

// File: rtl/mux_nx1_stream.sv
// N:1 streaming mux with explicit-select and round-robin modes, feeding a
// one-entry registered output stage with valid/ready handshakes.
module mux_nx1_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [SELW-1:0]    result_src
);

  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic [SELW-1:0]  src_q;
  logic [SELW-1:0]  ptr_q;

  logic             load_en;
  logic             found;
  logic [SELW-1:0]  cand;
  logic             grant;
  logic [WIDTH-1:0] cand_data;
  logic [SELW-1:0]  ptr_next;

  assign load_en = !valid_q || result_ready;

  // Pick the candidate channel; round-robin scans downward so the lowest
  // offset from ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    if (!mode) begin
      for (int i = 0; i < int'(N); i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          found = 1'b1;
          cand  = sel;
        end
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        for (int j = 0; j < int'(N); j++) begin
          if (j == (int'(ptr_q) + i) % int'(N) && in_valid[j]) begin
            found = 1'b1;
            cand  = SELW'(j);
          end
        end
      end
    end
  end

  assign grant = !reset && load_en && found;

  // One-hot accept strobe plus data select for the granted channel.
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (int'(cand) == i) begin
        in_ready[i] = grant;
        cand_data   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (int'(cand) + 1 == int'(N)) ? '0 : cand + 1'b1;

  // Output register, drain handling and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      src_q    <= '0;
      ptr_q    <= '0;
    end else begin
      if (grant) begin
        result_q <= cand_data;
        src_q    <= cand;
        valid_q  <= 1'b1;
        if (mode) begin
          ptr_q <= ptr_next;
        end
      end else if (result_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign result_src   = src_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: default N=4 instance plus an N=3 instance.
module tb_mux_nx1_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [127:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_src;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  result3;
  logic        result_valid3;
  logic        result_ready3;
  logic [1:0]  result_src3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_nx1_stream #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .sel          (sel),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_src   (result_src)
  );

  mux_nx1_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode3),
    .sel          (sel3),
    .in_data      (in_data3),
    .in_valid     (in_valid3),
    .in_ready     (in_ready3),
    .result       (result3),
    .result_valid (result_valid3),
    .result_ready (result_ready3),
    .result_src   (result_src3)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};

    reset         = 1'b1;
    mode          = 1'b0;
    sel           = 2'd0;
    in_data       = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_valid      = 4'b1111;
    result_ready  = 1'b1;
    mode3         = 1'b0;
    sel3          = 2'd3;
    in_data3      = {8'h33, 8'h22, 8'h11};
    in_valid3     = 3'b111;
    result_ready3 = 1'b1;

    // Reset state and in_ready suppression while reset is high.
    step();
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_src", result_src, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_in_ready3", in_ready3, 0);

    // Explicit select of channel 2; N=3 instance with out-of-range sel.
    reset = 1'b0;
    sel   = 2'd2;
    #1;
    check("sel2_in_ready", in_ready, 4'b0100);
    check("n3_sel3_in_ready", in_ready3, 3'b000);
    step();
    check("sel2_result", result, 32'h33333333);
    check("sel2_src", result_src, 2);
    check("sel2_valid", result_valid, 1);
    check("n3_sel3_valid", result_valid3, 0);

    sel3 = 2'd2;
    #1;
    check("n3_sel2_in_ready", in_ready3, 3'b100);
    step();
    check("n3_sel2_result", result3, 8'h33);
    check("n3_sel2_src", result_src3, 2);

    // Round-robin with all channels valid; pointer still 0 after mode=0 grants.
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_src_%0d", k), result_src, exp_rr[k]);
      check($sformatf("rr_valid_%0d", k), result_valid, 1);
    end

    // ptr is now 2: sparse valids 1010 serve 3, 1, 3.
    in_valid = 4'b1010;
    step();
    check("sparse_src_0", result_src, 3);
    step();
    check("sparse_src_1", result_src, 1);
    step();
    check("sparse_src_2", result_src, 3);
    check("sparse_data_2", result, 32'h44444444);

    // Backpressure: held word, no accepts.
    result_ready = 1'b0;
    #1;
    check("bp_in_ready_0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_result_%0d", k), result, 32'h44444444);
      check($sformatf("bp_valid_%0d", k), result_valid, 1);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
    end

    // Release: grant in the same cycle, valid stays high.
    mode         = 1'b0;
    sel          = 2'd0;
    in_valid     = 4'b1111;
    result_ready = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 4'b0001);
    step();
    check("rel_result", result, 32'h11111111);
    check("rel_src", result_src, 0);
    check("rel_valid", result_valid, 1);

    // Drain with no new grant: valid drops, data and src hold.
    in_valid = 4'b0000;
    step();
    check("drain_valid", result_valid, 0);
    check("drain_result", result, 32'h11111111);
    check("drain_src", result_src, 0);

    // Round-robin grant moves ptr to 1, then reset mid-stream.
    mode     = 1'b1;
    in_valid = 4'b1111;
    step();
    check("pre_rst_valid", result_valid, 1);
    check("pre_rst_src", result_src, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    step();
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);

    // After release, ptr=0 so 0101 picks channel 0 (ptr=1 would pick 2).
    reset    = 1'b0;
    in_valid = 4'b0101;
    step();
    check("post_rst_src", result_src, 0);
    check("post_rst_result", result, 32'h11111111);
    check("post_rst_valid", result_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
